// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding and default frame/oversampling
// parameters, common to the receiver, the baud generator and the transmitter.
package uart_rx_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit; both stages
// reset to RESET_VAL so an idle-high line does not look like a start bit after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability chain: first stage may go metastable, second stage is used downstream
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, validates the start bit at its midpoint, samples
// LSB-first data at bit midpoints and reports each frame with a one-clock pulse.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_r;
    rx_state_t            state_n;
    logic [TW-1:0]        tick_cnt_r;
    logic [TW-1:0]        tick_cnt_n;
    logic [BW-1:0]        bit_cnt_r;
    logic [BW-1:0]        bit_cnt_n;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_n;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_r;
    logic                 valid_n;
    logic                 ferr_r;
    logic                 ferr_n;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and output pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            shift_r    <= {DATA_BITS{1'b0}};
            data_r     <= {DATA_BITS{1'b0}};
            valid_r    <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            tick_cnt_r <= tick_cnt_n;
            bit_cnt_r  <= bit_cnt_n;
            shift_r    <= shift_n;
            data_r     <= data_n;
            valid_r    <= valid_n;
            ferr_r     <= ferr_n;
        end
    end

    // Next-state logic; everything holds between baud ticks, pulses default low
    always_comb begin
        state_n    = state_r;
        tick_cnt_n = tick_cnt_r;
        bit_cnt_n  = bit_cnt_r;
        shift_n    = shift_r;
        data_n     = data_r;
        valid_n    = 1'b0;
        ferr_n     = 1'b0;
        if (baud_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_n    = START;
                        tick_cnt_n = TICK_ZERO;
                    end else begin
                        state_n    = IDLE;
                    end
                end
                START: begin
                    if (tick_cnt_r == TICK_MID) begin
                        tick_cnt_n = TICK_ZERO;
                        bit_cnt_n  = BIT_ZERO;
                        // A start bit that is gone by its midpoint was only a glitch
                        if (!rx_s) begin
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TICK_ONE;
                    end
                end
                DATA: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        shift_n    = {rx_s, shift_r[DATA_BITS-1:1]};
                        tick_cnt_n = TICK_ZERO;
                        bit_cnt_n  = bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            state_n = DATA;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TICK_ONE;
                    end
                end
                STOP: begin
                    if (tick_cnt_r == TICK_LAST) begin
                        // Leaving at mid stop bit lets a back-to-back start bit be caught
                        state_n    = IDLE;
                        tick_cnt_n = TICK_ZERO;
                        bit_cnt_n  = BIT_ZERO;
                        if (rx_s) begin
                            data_n  = shift_r;
                            valid_n = 1'b1;
                        end else begin
                            ferr_n  = 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt_r + TICK_ONE;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    tick_cnt_n = TICK_ZERO;
                    bit_cnt_n  = BIT_ZERO;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    assign rx_data   = data_r;
    assign rx_valid  = valid_r;
    assign frame_err = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: baud_tick every 4 clk (one bit = 64 clk); expected
// frame results are queued as frames are driven and checked when the DUT pulses.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    logic       tick_en = 1'b1;
    logic [1:0] div = 2'd0;
    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk in four, gated by tick_en
    always @(negedge clk) begin
        div = div + 2'd1;
        baud_tick = tick_en && (div == 2'd0);
    end

    // Scoreboard: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rx_valid === 1'b1 || frame_err === 1'b1) begin
            total++;
            if (rx_valid === 1'b1 && frame_err === 1'b1) begin
                bad++;
                $display("FAIL both_pulses rx_valid=%b frame_err=%b required one-hot", rx_valid, frame_err);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse valid=%b ferr=%b data=%h required no pulse", rx_valid, frame_err, rx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (frame_err !== e.is_err || rx_data !== e.data) begin
                    bad++;
                    $display("FAIL pulse_content got ferr=%b data=%h required ferr=%b data=%h", frame_err, rx_data, e.is_err, e.data);
                end
            end
            if (rx_valid === 1'b1) n_valid++;
            if (frame_err === 1'b1) n_ferr++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit period; optionally freezes baud ticks for 200 clk in the middle of it
    task automatic drive_bit(input logic v, input bit freeze);
        int p0;
        rx = v;
        if (!freeze) begin
            wait_clk(BIT_CLK);
        end else begin
            wait_clk(BIT_CLK / 2);
            tick_en = 1'b0;
            p0 = n_valid + n_ferr;
            wait_clk(200);
            total++;
            if (n_valid + n_ferr !== p0) begin
                bad++;
                $display("FAIL freeze_no_pulse pulses=%0d required %0d", n_valid + n_ferr, p0);
            end
            tick_en = 1'b1;
            wait_clk(BIT_CLK / 2);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int freeze_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], i == freeze_bit);
        drive_bit(stop, 1'b0);
        rx = 1'b1;
    endtask

    task automatic check_frames(input string name, input int v0, input int dv,
                                input int f0, input int df, input logic [7:0] data_exp);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL %s_missing_pulse pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
        total++;
        if (n_valid - v0 !== dv || n_ferr - f0 !== df) begin
            bad++;
            $display("FAIL %s_pulse_count valid=%0d ferr=%0d required valid=%0d ferr=%0d",
                     name, n_valid - v0, n_ferr - f0, dv, df);
        end
        total++;
        if (rx_data !== data_exp) begin
            bad++;
            $display("FAIL %s_rx_data got=%h required=%h", name, rx_data, data_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(5);
        total++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_state valid=%b ferr=%b data=%h required 0 0 00", rx_valid, frame_err, rx_data);
        end
        reset = 1'b0;
        wait_clk(20);
    endtask

    task automatic test_single();
        int v0 = n_valid;
        int f0 = n_ferr;
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 1'b1, -1);
        last_good = 8'h55;
        wait_clk(20);
        check_frames("single", v0, 1, f0, 0, 8'h55);
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid;
        int f0 = n_ferr;
        exp_q.push_back({1'b0, 8'hA3});
        exp_q.push_back({1'b0, 8'h0F});
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        last_good = 8'h0F;
        wait_clk(20);
        check_frames("b2b", v0, 2, f0, 0, 8'h0F);
    endtask

    task automatic test_glitch();
        int v0 = n_valid;
        int f0 = n_ferr;
        rx = 1'b0;
        wait_clk(12);
        rx = 1'b1;
        wait_clk(100);
        check_frames("glitch", v0, 0, f0, 0, last_good);
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1, -1);
        last_good = 8'h3C;
        wait_clk(20);
        check_frames("after_glitch", v0, 1, f0, 0, 8'h3C);
    endtask

    task automatic test_frame_err();
        int v0 = n_valid;
        int f0 = n_ferr;
        // rx_data must keep the last good byte received before this frame
        exp_q.push_back({1'b1, last_good});
        send_frame(8'h81, 1'b0, -1);
        wait_clk(100);
        check_frames("frame_err", v0, 0, f0, 1, last_good);
    endtask

    task automatic test_reset_mid();
        int v0 = n_valid;
        int f0 = n_ferr;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        rx = 1'b1;
        wait_clk(4 * BIT_CLK + BIT_CLK / 2);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        wait_clk(BIT_CLK / 2 + 4 * BIT_CLK);
        last_good = 8'h00;
        check_frames("reset_mid", v0, 0, f0, 0, 8'h00);
        exp_q.push_back({1'b0, 8'hC6});
        send_frame(8'hC6, 1'b1, -1);
        last_good = 8'hC6;
        wait_clk(20);
        check_frames("after_reset", v0, 1, f0, 0, 8'hC6);
    endtask

    task automatic test_freeze();
        int v0 = n_valid;
        int f0 = n_ferr;
        exp_q.push_back({1'b0, 8'h96});
        send_frame(8'h96, 1'b1, 3);
        last_good = 8'h96;
        wait_clk(20);
        check_frames("freeze", v0, 1, f0, 0, 8'h96);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_freeze();
        wait_clk(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
